// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 16 lines x 256 bits. A miss stalls the pipeline, optionally writes back the
// dirty victim, refills the line, then replays the access as a hit in IDLE.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         MemRead_i,
  input  logic         MemWrite_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  output logic         MemStall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

  state_e state_q, state_d;

  logic [15:0]  valid_q;
  logic [15:0]  dirty_q;
  logic [22:0]  tag_q  [16];
  logic [255:0] data_q [16];

  logic [22:0]  addr_tag;
  logic [3:0]   index;
  logic [2:0]   word;
  logic [7:0]   word_lsb;
  logic         req;
  logic         hit;
  logic         store_hit;
  logic         refill_done;
  logic [255:0] line;
  logic [31:0]  line_word;

  // Byte offset bits are not used by a word-granular cache.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr_i[1:0];

  assign addr_tag  = addr_i[31:9];
  assign index     = addr_i[8:5];
  assign word      = addr_i[4:2];
  assign word_lsb  = {word, 5'b0};
  assign line      = data_q[index];
  assign line_word = line[word_lsb +: 32];

  assign req        = MemRead_i | MemWrite_i;
  assign hit        = (state_q == StIdle) & valid_q[index] & (tag_q[index] == addr_tag);
  // A simultaneous read and write is a store.
  assign store_hit  = hit & MemWrite_i;
  assign MemStall_o = req & ~hit;

  // Load data only for a pure load hit; zero otherwise.
  always_comb begin
    rdata_o = '0;
    if (hit && MemRead_i && !MemWrite_i) begin
      rdata_o = line_word;
    end
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    refill_done  = 1'b0;
    case (state_q)
      StIdle: begin
        // mem_ack_i is deliberately ignored here.
        if (req && !hit) begin
          state_d = (valid_q[index] && dirty_q[index]) ? StWriteback : StRefill;
        end
      end
      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[index], index, 5'b0};
        mem_data_o   = line;
        if (mem_ack_i) begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {addr_tag, index, 5'b0};
        if (mem_ack_i) begin
          state_d     = StIdle;
          refill_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and per-line valid/dirty; reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill_done) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are not reset; validity is tracked by valid_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill_done) begin
        tag_q[index]  <= addr_tag;
        data_q[index] <= mem_data_i;
      end else if (store_hit) begin
        data_q[index][word_lsb +: 32] <= wdata_i;
      end
    end
  end

endmodule
